// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request channel between the fetch stage (master) and
// the instruction memory (slave).
//
// Handshake: the master holds IMEM_REQ=1 with a stable IMEM_ADDR. The slave
// answers by raising IMEM_READY for one cycle with IMEM_RDATA valid in that
// same cycle. A request is complete in the cycle with IMEM_REQ=1 and
// IMEM_READY=1. Until then the address must not change.
interface if_fetch_stage_if;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_READY;
  logic [31:0] IMEM_RDATA;

  modport master (
    output IMEM_REQ,
    output IMEM_ADDR,
    input  IMEM_READY,
    input  IMEM_RDATA
  );

  modport slave (
    input  IMEM_REQ,
    input  IMEM_ADDR,
    output IMEM_READY,
    output IMEM_RDATA
  );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: owns the PC, talks to instruction memory over a
// req/ready channel and fills the IF/ID pipeline register. Hazard-unit
// stalls, memory wait states and branch/jump redirects are handled here.
// A redirect that lands while a memory request is still outstanding parks
// the FSM in DROP. The stale address stays on the bus until the memory
// answers, and that answer is thrown away.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   PCWrite,
  input  logic                   IFIDWrite,
  input  logic                   IF_Flush,
  input  logic [31:0]            Redirect_PC,
  if_fetch_stage_if.master       imem,
  output logic [31:0]            IF_PC_4,
  output logic [31:0]            ID_PC_4,
  output logic [31:0]            ID_INSTR,
  output logic                   ID_VALID,
  output logic                   Fetch_Stall,
  output logic [1:0]             dbg_state_o
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_DROP  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] stale_q, stale_d;
  logic        req_q;
  logic [31:0] id_pc4_q, id_pc4_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  // State and pipeline registers; reset abandons any outstanding request.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      stale_q    <= 32'h0;
      req_q      <= 1'b0;
      id_pc4_q   <= 32'h0;
      id_instr_q <= NOP_INSTR;
      id_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      stale_q    <= stale_d;
      req_q      <= 1'b1;
      id_pc4_q   <= id_pc4_d;
      id_instr_q <= id_instr_d;
      id_valid_q <= id_valid_d;
    end
  end

  // Next-state, PC and IF/ID update. Nothing moves until the first request
  // has gone out after reset.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    stale_d    = stale_q;
    id_pc4_d   = id_pc4_q;
    id_instr_d = id_instr_q;
    id_valid_d = id_valid_q;

    if (req_q) begin
      if (state_q == S_DROP) begin
        // The word returning for the stale address is never used.
        if (IF_Flush) begin
          pc_d       = Redirect_PC;
          id_pc4_d   = 32'h0;
          id_instr_d = NOP_INSTR;
          id_valid_d = 1'b0;
        end else if (IFIDWrite) begin
          id_pc4_d   = pc_plus4;
          id_instr_d = NOP_INSTR;
          id_valid_d = 1'b0;
        end
        // Once the stale request completes, the bus is free for the new PC.
        if (imem.IMEM_READY) begin
          state_d = S_FETCH;
        end
      end else begin
        if (IF_Flush) begin
          pc_d       = Redirect_PC;
          id_pc4_d   = 32'h0;
          id_instr_d = NOP_INSTR;
          id_valid_d = 1'b0;
          if (imem.IMEM_READY) begin
            state_d = S_FETCH;
          end else begin
            // The address must stay put until memory answers.
            state_d = S_DROP;
            stale_d = pc_q;
          end
        end else if (imem.IMEM_READY) begin
          state_d = S_FETCH;
          // On a hazard stall the word is discarded and PC re-requested.
          if (PCWrite && IFIDWrite) begin
            pc_d       = pc_plus4;
            id_pc4_d   = pc_plus4;
            id_instr_d = imem.IMEM_RDATA;
            id_valid_d = 1'b1;
          end
        end else begin
          state_d = S_WAIT;
          if (IFIDWrite) begin
            id_pc4_d   = pc_plus4;
            id_instr_d = NOP_INSTR;
            id_valid_d = 1'b0;
          end
        end
      end
    end
  end

  assign imem.IMEM_REQ  = req_q;
  assign imem.IMEM_ADDR = (state_q == S_DROP) ? stale_q : pc_q;
  assign Fetch_Stall    = req_q && ((state_q == S_DROP) || !imem.IMEM_READY);
  assign IF_PC_4        = pc_plus4;
  assign ID_PC_4        = id_pc4_q;
  assign ID_INSTR       = id_instr_q;
  assign ID_VALID       = id_valid_q;
  assign dbg_state_o    = state_q;

endmodule

// File: doc/if_fetch_stage.md
IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, the PC loaded on reset.
REQ-002 The block SHALL have parameter NOP_INSTR, default 32'h0000_0000, the instruction word of an IF/ID bubble.
REQ-003 The block SHALL have port CLK  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port RESET  input  1  reset, asynchronous and active-low.
REQ-005 The block SHALL have port PCWrite  input  1  from hazard unit; 0 = hold PC.
REQ-006 The block SHALL have port IFIDWrite  input  1  from hazard unit; 0 = hold IF/ID register.
REQ-007 The block SHALL have port IF_Flush  input  1  from hazard unit; 1 = taken branch or jump, redirect fetch.
REQ-008 The block SHALL have port Redirect_PC  input  32  branch/jump target, sampled only when IF_Flush=1.
REQ-009 The block SHALL have ports IMEM_REQ  output  1, IMEM_ADDR  output  32, IMEM_READY  input  1, IMEM_RDATA  input  32: the instruction-memory request/ready handshake, with RDATA valid in the cycle READY=1.
REQ-010 The block SHALL have port IF_PC_4  output  32  PC+4 of the current fetch address, driven to the hazard unit.
REQ-011 The block SHALL have ports ID_PC_4  output  32, ID_INSTR  output  32, ID_VALID  output  1: the IF/ID pipeline register.
REQ-012 The block SHALL have port Fetch_Stall  output  1  1 when no instruction is delivered this cycle because memory is not ready.

Function
REQ-013 The FSM SHALL have three states: FETCH (request PC), WAIT (request outstanding, not yet ready), DROP (outstanding request made stale by a redirect).
REQ-014 IMEM_REQ SHALL be 1 in every state after reset; IMEM_ADDR SHALL be PC in FETCH/WAIT and the stale address in DROP.
REQ-015 Once IMEM_REQ=1 with READY=0, IMEM_ADDR SHALL remain stable until the cycle READY=1.
REQ-016 IF_PC_4 SHALL equal PC+4 modulo 2^32; 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-017 In FETCH/WAIT with READY=1, IF_Flush=0, PCWrite=1, IFIDWrite=1: IF/ID SHALL load {PC+4, IMEM_RDATA, VALID=1}, PC SHALL load PC+4, and the next state SHALL be FETCH.
REQ-018 With READY=1 and PCWrite=0 or IFIDWrite=0 (hazard stall), PC and IF/ID SHALL hold, the fetched word SHALL be discarded, and the same address SHALL be re-requested next cycle.
REQ-019 In FETCH/WAIT with READY=0 and IF_Flush=0: the state SHALL become WAIT, PC SHALL hold, Fetch_Stall SHALL be 1, and IF/ID SHALL load a bubble {PC+4, NOP_INSTR, VALID=0} if IFIDWrite=1, else hold.
REQ-020 IF_Flush=1 SHALL take priority over PCWrite/IFIDWrite: IF/ID SHALL load {32'h0, NOP_INSTR, VALID=0} and PC SHALL load Redirect_PC in the same edge.
REQ-021 On IF_Flush=1 in FETCH/WAIT with READY=1, the next state SHALL be FETCH at Redirect_PC.
REQ-022 On IF_Flush=1 in FETCH/WAIT with READY=0, the stale address SHALL be kept on IMEM_ADDR and the next state SHALL be DROP.
REQ-023 In DROP, the returning word SHALL be discarded; READY=1 SHALL move the state to FETCH; Fetch_Stall SHALL be 1; and IF/ID SHALL take bubbles if IFIDWrite=1.
REQ-024 A second IF_Flush while in DROP SHALL overwrite PC with the new Redirect_PC and keep the state DROP.
REQ-025 Latency SHALL be: instruction at address A, READY in cycle n, appears on ID_INSTR after edge n; with zero-wait memory, one instruction per cycle.

Reset
REQ-026 While RESET=0, asynchronously: PC=RESET_PC, state=FETCH, ID_PC_4=32'h0, ID_INSTR=NOP_INSTR, ID_VALID=0, IMEM_REQ=0, Fetch_Stall=0.
REQ-027 After RESET rises, the first request SHALL issue on the next cycle; a reset asserted mid-WAIT/DROP SHALL abandon the outstanding request with no IF/ID update.

Verification
REQ-028 Zero-wait READY=1 from reset -> IMEM_ADDR 0,4,8,C on consecutive cycles; ID_PC_4 4,8,C,10; ID_VALID=1.
REQ-029 PCWrite=IFIDWrite=0 for 2 cycles at PC=8 -> IMEM_ADDR stays 8, ID_INSTR holds word@4, then resumes 8,C.
REQ-030 READY=0 for 3 cycles at PC=10 -> IMEM_ADDR=10 stable, Fetch_Stall=1, three bubbles (ID_VALID=0), then word@10 valid.
REQ-031 IF_Flush=1 with Redirect_PC=40, READY=1 -> next IMEM_ADDR=40, ID_VALID=0 for that edge.
REQ-032 IF_Flush=1 (Redirect_PC=80) during WAIT at 20, READY after 2 cycles -> IMEM_ADDR=20 until ready, word@20 never reaches ID, then IMEM_ADDR=80.
REQ-033 RESET low mid-WAIT -> outputs at REQ-026 values immediately, without a clock edge.
